// File: rtl/hex_seg7_scan_pkg.sv
// Shared types and the active-low a..g decode table for the hex 7-segment scanner.
// Segment vectors are [0:6] so that seg[0] is segment a and literals read a..g left to right.
package hex_seg7_pkg;

    typedef logic [0:6] seg7_t;

    localparam seg7_t SEG_OFF = 7'b1111111;

    localparam seg7_t SEG_LUT [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

endpackage

// File: rtl/hex_seg7_scan_if.sv
// Host-side capture signals and board-side display pins of the hex scanner.
// master drives value/dp/load/blank and observes the pins; slave is the scanner itself.
interface hex_seg7_scan_if #(
    parameter int N_DIGITS = 4
) ();
    import hex_seg7_pkg::*;

    logic [4*N_DIGITS-1:0] value_in;
    logic [N_DIGITS-1:0]   dp_in;
    logic                  load;
    logic                  blank;
    seg7_t                 seg;
    logic                  dp;
    logic [N_DIGITS-1:0]   an;
    logic                  frame_done;

    modport master (
        output value_in, dp_in, load, blank,
        input  seg, dp, an, frame_done
    );

    modport slave (
        input  value_in, dp_in, load, blank,
        output seg, dp, an, frame_done
    );

endinterface

// File: rtl/hex_seg7_scan_lut.sv
// Combinational nibble to active-low a..g segment decode.
module hex_seg7_lut
    import hex_seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output seg7_t      seg
);

    assign seg = SEG_LUT[nibble];

endmodule

// File: rtl/hex_seg7_scan.sv
// Time-multiplexed hex driver for N common-anode digits with frame-synchronous double buffering.
// Define HEX_SEG7_SCAN_LZB_EN to dark the digits above the most-significant nonzero nibble.
module hex_seg7_scan #(
    parameter int N_DIGITS = 4,
    parameter int CLK_DIV  = 50000
) (
    input  logic            clk,
    input  logic            reset,
    hex_seg7_scan_if.slave  bus
);
    import hex_seg7_pkg::*;

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int PRE_W = $clog2(CLK_DIV);
    localparam int VAL_W = 4 * N_DIGITS;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

    logic [PRE_W-1:0]    presc;
    logic [IDX_W-1:0]    idx;
    logic [VAL_W-1:0]    shadow_val, disp_val, commit_val;
    logic [N_DIGITS-1:0] shadow_dp, disp_dp, commit_dp;
    logic [N_DIGITS-1:0] disp_lz, lz_next;
    logic                pending;
    logic                slot_end, frame_wrap;
    logic [3:0]          nib_sel;
    logic                dp_sel, lz_sel;
    seg7_t               seg_dec;

    assign slot_end   = (presc == PRE_LAST);
    assign frame_wrap = slot_end && (idx == IDX_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
            idx   <= '0;
        end else if (slot_end) begin
            presc <= '0;
            idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // A load landing on the wrap cycle bypasses the shadow so it is never a frame late.
    always_comb begin
        commit_val = bus.load ? bus.value_in : shadow_val;
        commit_dp  = bus.load ? bus.dp_in    : shadow_dp;
    end

`ifdef HEX_SEG7_SCAN_LZB_EN
    logic lz_seen;

    always_comb begin
        lz_next = '0;
        lz_seen = 1'b0;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            if (commit_val[4*i +: 4] != 4'h0) lz_seen = 1'b1;
            lz_next[i] = ~lz_seen;
        end
    end
`else
    assign lz_next = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_val <= '0;
            shadow_dp  <= '0;
            disp_val   <= '0;
            disp_dp    <= '0;
            disp_lz    <= '0;
            pending    <= 1'b0;
        end else begin
            if (bus.load) begin
                shadow_val <= bus.value_in;
                shadow_dp  <= bus.dp_in;
            end
            if (frame_wrap && (bus.load || pending)) begin
                disp_val <= commit_val;
                disp_dp  <= commit_dp;
                disp_lz  <= lz_next;
            end
            if (frame_wrap)
                pending <= 1'b0;
            else if (bus.load)
                pending <= 1'b1;
        end
    end

    always_comb begin
        nib_sel = '0;
        dp_sel  = 1'b0;
        lz_sel  = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                nib_sel = disp_val[4*i +: 4];
                dp_sel  = disp_dp[i];
                lz_sel  = disp_lz[i];
            end
        end
    end

    hex_seg7_lut u_lut (
        .nibble (nib_sel),
        .seg    (seg_dec)
    );

    // Count 0 of each slot keeps every anode off so the previous digit cannot ghost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.seg        <= SEG_OFF;
            bus.dp         <= 1'b1;
            bus.an         <= '1;
            bus.frame_done <= 1'b0;
        end else begin
            bus.frame_done <= frame_wrap;
            if (bus.blank) begin
                bus.seg <= SEG_OFF;
                bus.dp  <= 1'b1;
                bus.an  <= '1;
            end else begin
                bus.seg <= lz_sel ? SEG_OFF : seg_dec;
                bus.dp  <= ~dp_sel;
                bus.an  <= (presc == '0) ? '1 : ~(N_DIGITS'(1) << idx);
            end
        end
    end

endmodule
